// File: rtl/mux2_pc_jump_pkg.sv
// Shared RISC-V constants: program-counter width and reset vector.
package mux2_pc_jump_pkg;

    localparam int          PC_WIDTH        = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/mux2_pc_jump.sv
// Next-PC select: Out_Mux is combinational (0 cycles); Out_Reg/Jump_Taken load one cycle later when en=1.
// No flow control: en=0 simply holds the registered outputs.
module mux2_pc_jump
    import mux2_pc_jump_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SEL,
    input  logic [WIDTH-1:0] Dato1,
    input  logic [WIDTH-1:0] Dato2,
    input  logic             en,
    output logic [WIDTH-1:0] Out_Mux,
    output logic [WIDTH-1:0] Out_Reg,
    output logic             Jump_Taken
);

    // An unknown select poisons the whole word in simulation rather than silently picking a side.
    always_comb begin
        case (SEL)
            1'b0:    Out_Mux = Dato1;
            1'b1:    Out_Mux = Dato2;
            default: Out_Mux = 'x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Out_Reg    <= RESET_VALUE;
            Jump_Taken <= 1'b0;
        end else if (en) begin
            Out_Reg    <= Out_Mux;
            Jump_Taken <= SEL;
        end
    end

endmodule

// File: tb/tb_mux2_pc_jump.sv
module tb_mux2_pc_jump;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst = 1'b0;
    logic        SEL = 1'b0;
    logic [31:0] Dato1 = '0;
    logic [31:0] Dato2 = '0;
    logic        en = 1'b0;
    logic [31:0] Out_Mux;
    logic [31:0] Out_Reg;
    logic        Jump_Taken;

    mux2_pc_jump dut (
        .clk        (clk),
        .rst        (rst),
        .SEL        (SEL),
        .Dato1      (Dato1),
        .Dato2      (Dato2),
        .en         (en),
        .Out_Mux    (Out_Mux),
        .Out_Reg    (Out_Reg),
        .Jump_Taken (Jump_Taken)
    );

    initial forever #5 clk = clk_run ? ~clk : clk;

    int checks = 0;
    int passes = 0;

    // Expected {Out_Reg, Jump_Taken} after each clock edge, oldest first.
    logic [32:0] sb[$];

    // Reference state: what the registers should hold after the last edge.
    logic [31:0] cur_reg;
    logic        cur_jt;
    bit          cur_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle of stimulus: drive on the falling edge, check the
    // combinational path and pre-edge register hold, then push the post-edge expectation.
    task automatic step(input string name, input logic r, input logic e, input logic s,
                        input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] nxt_reg;
        logic        nxt_jt;
        @(negedge clk);
        rst = r; en = e; SEL = s; Dato1 = d1; Dato2 = d2;
        #1;
        check({name, "_mux"}, Out_Mux, s ? d2 : d1);
        if (cur_valid) begin
            check({name, "_reg_pre"}, Out_Reg, cur_reg);
            check({name, "_jt_pre"}, {31'b0, Jump_Taken}, {31'b0, cur_jt});
        end
        if (r) begin
            nxt_reg = 32'h0;
            nxt_jt  = 1'b0;
        end else if (e) begin
            nxt_reg = s ? d2 : d1;
            nxt_jt  = s;
        end else begin
            nxt_reg = cur_reg;
            nxt_jt  = cur_jt;
        end
        if (r || cur_valid) begin
            sb.push_back({nxt_reg, nxt_jt});
            cur_reg   = nxt_reg;
            cur_jt    = nxt_jt;
            cur_valid = 1;
        end
    endtask

    // Monitor: each edge the registers present a new value; compare to the oldest expectation.
    always @(posedge clk) begin
        logic [32:0] exp;
        #1;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("out_reg", Out_Reg, exp[32:1]);
            check("jump_taken", {31'b0, Jump_Taken}, {31'b0, exp[0]});
        end
    end

    initial begin
        // Combinational path with no clock running.
        SEL = 1'b0; Dato1 = 32'hABCDEF20; Dato2 = 32'h0;
        #1 check("noclk_sel0", Out_Mux, 32'hABCDEF20);
        SEL = 1'b1; Dato2 = 32'hABCDEF17;
        #1 check("noclk_sel1", Out_Mux, 32'hABCDEF17);
        SEL = 1'b0; Dato1 = 32'h00000004;
        for (int i = 0; i < 4; i++) begin
            Dato2 = i[0] ? 32'h0 : 32'hFFFFFFFF;
            #1 check("unsel_toggle", Out_Mux, 32'h00000004);
        end

        clk_run = 1'b1;

        step("reset", 1'b1, 1'b1, 1'b1, 32'h11111111, 32'hABCDEF17);
        step("reset_no_en", 1'b1, 1'b0, 1'b1, 32'h22222222, 32'h33333333);
        step("load_jump", 1'b0, 1'b1, 1'b1, 32'hABCDEF20, 32'hABCDEF17);
        for (int i = 0; i < 3; i++)
            step("hold", 1'b0, 1'b0, i[0], $urandom, $urandom);
        for (int i = 0; i < 4; i++)
            step("seq_unsel", 1'b0, 1'b1, 1'b0, 32'h00000004, i[0] ? 32'h0 : 32'hFFFFFFFF);
        step("rst_over_en", 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom, $urandom);

        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
